hamming_tx_ctrl: RTL

Serial transmit controller for the Hamming(7,4) encoder (hamming_emisor). Accepts 4-bit data nibbles over a valid/ready handshake and instantiates hamming_emisor internally. Latches the 7-bit codeword and shifts it out LSB-first on a single line, framed with a start and a stop bit, at a programmable bit period. Sits between a nibble source (e.g. switch/UART logic) and a board pin or loopback to the receiver side.

---
 rtl/hamming_tx_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hamming_tx_ctrl.sv
// Hamming(7,4) serial transmitter: start bit, codeword LSB-first, stop bit.
// Define HAMMING_TX_PARITY_EN to append an overall even-parity bit (8,4).
module hamming_emisor (
  input  logic [3:0] d_in,
  output logic [6:0] m_out
);
  assign m_out = {
    d_in[3],
    d_in[2],
    d_in[1],
    d_in[1] ^ d_in[2] ^ d_in[3],
    d_in[0],
    d_in[0] ^ d_in[2] ^ d_in[3],
    d_in[0] ^ d_in[1] ^ d_in[3]
  };
endmodule

module hamming_tx_ctrl #(
  parameter int   CLK_DIV    = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_in,
  input  logic       d_valid,
  output logic       d_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
`ifdef HAMMING_TX_PARITY_EN
  output logic [7:0] cw_dbg
`else
  output logic [6:0] cw_dbg
`endif
);

  localparam int CW_W = $bits(cw_dbg);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST = 3'(CW_W - 1);

  logic [6:0]      m_out;
  logic [CW_W-1:0] cw_next;
  logic [CW_W-1:0] shreg;
  logic [1:0]      state;
  logic [15:0]     div_cnt;
  logic [2:0]      bit_idx;
  logic            wrap;

  hamming_emisor u_enc (
    .d_in  (d_in),
    .m_out (m_out)
  );

`ifdef HAMMING_TX_PARITY_EN
  assign cw_next = {^m_out, m_out};
`else
  assign cw_next = m_out;
`endif

  assign wrap = (div_cnt == DIV_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      d_ready <= 1'b1;
      done    <= 1'b0;
      cw_dbg  <= '0;
      shreg   <= '0;
      div_cnt <= '0;
      bit_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_valid && d_ready) begin
            shreg   <= cw_next;
            cw_dbg  <= cw_next;
            tx      <= ~IDLE_LEVEL;
            d_ready <= 1'b0;
            div_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (wrap) begin
            div_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DATA: begin
          if (wrap) begin
            div_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx    <= IDLE_LEVEL;
              state <= STOP;
              // single-cycle bits: the first stop cycle is also the last
              done  <= (DIV_LAST == 16'd0);
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        STOP: begin
          if (wrap) begin
            div_cnt <= '0;
            d_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 16'd1;
            done    <= (div_cnt + 16'd1 == DIV_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
